// File: rtl/dcdc_sync.sv
// Sync-clock generator for an external DC-DC converter SYNC pin.
// Emits clk/DIVIDER while enabled, otherwise a software-selected static level.
module dcdc_sync #(
    parameter int unsigned DIVIDER = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic state_out,
    output logic dcdc_clk
);

    localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] HALF = CW'(DIVIDER / 2);

    if (DIVIDER < 2) begin : g_divider_check
        $error("dcdc_sync: DIVIDER must be >= 2");
    end

    logic [1:0]    en_sync_q, en_sync_d;
    logic [1:0]    st_sync_q, st_sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          dclk_q, dclk_d;
    logic          en_s, st_s, cnt_wrap;

    assign en_s = en_sync_q[1];
    assign st_s = st_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync_q <= '0;
            st_sync_q <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            dclk_q    <= 1'b0;
        end else begin
            en_sync_q <= en_sync_d;
            st_sync_q <= st_sync_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            dclk_q    <= dclk_d;
        end
    end

    // Mode only changes at the wrap edge so a period is never cut short.
    always_comb begin
        en_sync_d = {en_sync_q[0], en};
        st_sync_d = {st_sync_q[0], state_out};
        cnt_wrap  = (cnt_q == LAST);
        cnt_d     = cnt_wrap ? '0 : cnt_q + CW'(1);
        run_d     = cnt_wrap ? en_s : run_q;
        dclk_d    = run_q ? (cnt_q < HALF) : st_s;
    end

    assign dcdc_clk = dclk_q;

endmodule

// File: tb/tb_dcdc_sync.sv
// Directed bench for dcdc_sync at DIVIDER = 10, 7 and 2 sharing one set of inputs.
`timescale 1ns/1ps
module tb_dcdc_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic state_out = 1'b0;
    logic dclk10, dclk7, dclk2;
    int   checks = 0;
    int   errors = 0;

    always #2.5 clk = ~clk;

    dcdc_sync #(.DIVIDER(10)) u_div10 (.clk(clk), .rst(rst), .en(en), .state_out(state_out), .dcdc_clk(dclk10));
    dcdc_sync #(.DIVIDER(7))  u_div7  (.clk(clk), .rst(rst), .en(en), .state_out(state_out), .dcdc_clk(dclk7));
    dcdc_sync #(.DIVIDER(2))  u_div2  (.clk(clk), .rst(rst), .en(en), .state_out(state_out), .dcdc_clk(dclk2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst released 1 ns after an edge; the following edge is edge 1 with cnt = 0.
    task automatic apply_reset(input logic en_v, input logic st_v);
        rst = 1'b1;
        en = en_v;
        state_out = st_v;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst = 1'b1;
        en = 1'b1;
        state_out = 1'b1;
        #1;
        for (int n = 1; n <= 6; n++) begin
            step();
            got = {dclk10, dclk7, dclk2};
            checks++;
            if (got !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %b expected 000", n, got);
            end
        end
        en = 1'b0;
        state_out = 1'b0;
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            got = {dclk10, dclk7, dclk2};
            checks++;
            if (got !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_idle edge %0d: got %b expected 000", n, got);
            end
        end
    endtask

    task automatic test_div10_run();
        logic exp;
        apply_reset(1'b1, 1'b0);
        for (int n = 1; n <= 110; n++) begin
            step();
            exp = (n >= 11) && (((n - 11) % 10) < 5);
            checks++;
            if (dclk10 !== exp) begin
                errors++;
                $display("FAIL div10_run edge %0d: got %b expected %b", n, dclk10, exp);
            end
        end
    endtask

    task automatic test_div7_div2_run();
        logic exp7, exp2;
        apply_reset(1'b1, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            step();
            exp7 = (n >= 8) && (((n - 8) % 7) < 3);
            exp2 = (n >= 5) && (((n - 5) % 2) == 0);
            checks++;
            if (dclk7 !== exp7) begin
                errors++;
                $display("FAIL div7_run edge %0d: got %b expected %b", n, dclk7, exp7);
            end
            checks++;
            if (dclk2 !== exp2) begin
                errors++;
                $display("FAIL div2_run edge %0d: got %b expected %b", n, dclk2, exp2);
            end
        end
    endtask

    task automatic test_disable(input logic st_v);
        logic exp;
        apply_reset(1'b1, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            step();
            exp = ((n >= 11) && (n <= 15)) || (st_v && (n >= 21));
            checks++;
            if (dclk10 !== exp) begin
                errors++;
                $display("FAIL disable_st%0b edge %0d: got %b expected %b", st_v, n, dclk10, exp);
            end
            if (n == 12) begin
                en = 1'b0;
                state_out = st_v;
            end
        end
        state_out = 1'b0;
    endtask

    task automatic test_static_level();
        logic exp;
        apply_reset(1'b0, 1'b0);
        repeat (5) step();
        state_out = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k >= 3);
            checks++;
            if (dclk10 !== exp) begin
                errors++;
                $display("FAIL static_rise edge %0d: got %b expected %b", k, dclk10, exp);
            end
        end
        state_out = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (k < 3);
            checks++;
            if (dclk10 !== exp) begin
                errors++;
                $display("FAIL static_fall edge %0d: got %b expected %b", k, dclk10, exp);
            end
        end
    endtask

    task automatic test_short_en_pulse();
        logic exp;
        apply_reset(1'b0, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            step();
            checks++;
            if (dclk10 !== 1'b0) begin
                errors++;
                $display("FAIL short_pulse_missed edge %0d: got %b expected 0", n, dclk10);
            end
            if (n == 3) en = 1'b1;
            if (n == 6) en = 1'b0;
        end
        apply_reset(1'b0, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            step();
            exp = (n >= 11) && (n <= 15);
            checks++;
            if (dclk10 !== exp) begin
                errors++;
                $display("FAIL short_pulse_caught edge %0d: got %b expected %b", n, dclk10, exp);
            end
            if (n == 6) en = 1'b1;
            if (n == 9) en = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        logic exp;
        apply_reset(1'b1, 1'b0);
        repeat (13) step();
        checks++;
        if (dclk10 !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre_reset: got %b expected 1", dclk10);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dclk10 !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async_clear: got %b expected 0", dclk10);
        end
        for (int n = 1; n <= 3; n++) begin
            step();
            checks++;
            if (dclk10 !== 1'b0) begin
                errors++;
                $display("FAIL midrun_reset_hold edge %0d: got %b expected 0", n, dclk10);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            exp = (n >= 11) && (n <= 15);
            checks++;
            if (dclk10 !== exp) begin
                errors++;
                $display("FAIL midrun_restart edge %0d: got %b expected %b", n, dclk10, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div10_run();
        test_div7_div2_run();
        test_disable(1'b0);
        test_disable(1'b1);
        test_static_level();
        test_short_en_pulse();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
